pg_load_monitor: RTL
====================

# pg_load_monitor

Parametrised, epoch-windowed successor to the router load tracker. It counts per-port link utilisation over a fixed window of EPOCH_LEN cycles, with saturating counters. At each window boundary it publishes a registered snapshot of per-port and router load, together with a low-load flag for the power-gating controller. It sits after route computation in each router and feeds the PG decision logic.

## Interface
- NUM_PORTS, 4: number of tracked network ports; bit i of every vector is port i.
- CNT_W, 8: width of each per-port counter and of each port_load field.
- EPOCH_LEN, 256: window length in cycles; legal range is 2..65535.
- LOW_THRESH, 32: router_load strictly below this value sets low_load.
- SUM_W: derived, fixed at CNT_W + $clog2(NUM_PORTS); not overridable.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- pg_enable  in  1  power-gate event; synchronously clears the counters and the epoch timer.
- valid  in  NUM_PORTS  flit present on the port this cycle.
- productive_vector  in  NUM_PORTS  port is productive for a flit this cycle.
- port_status  in  NUM_PORTS*`PORT_STAT_SIZE  per-port status; field i is bits [i*`PORT_STAT_SIZE +: `PORT_STAT_SIZE].
- port_load  out  NUM_PORTS*CNT_W  snapshot per-port load; field i is bits [i*CNT_W +: CNT_W].
- router_load  out  SUM_W  snapshot sum of all port_load fields.
- load_valid  out  1  one-cycle pulse: a new snapshot is on the outputs.
- low_load  out  1  registered; equals (router_load < LOW_THRESH).

## Operation
- **Event per port i per cycle:**
  - (valid[i] and status == `ACTIVE) or (productive_vector[i] and status == `INACTIVE).
  - Any other status value never counts.
- **Per-port counter cnt[i], CNT_W bits:**
  - Increments by 1 on an event.
  - Saturates at 2^CNT_W-1 and never wraps.
- **Epoch timer, $clog2(EPOCH_LEN) bits:**
  - Counts 0..EPOCH_LEN-1, then wraps to 0.
  - The cycle in which the timer equals EPOCH_LEN-1 is the boundary cycle.
- **Boundary cycle (pg_enable low):**
  - Snapshot value for port i = cnt[i] plus that cycle's event, saturated.
  - The snapshot is loaded into port_load.
  - router_load is the sum of the new port_load fields.
  - low_load is recomputed from the new router_load.
  - load_valid is set for the next cycle.
  - cnt[i] is cleared to 0, so the boundary cycle's event is not double-counted.
- **pg_enable high:**
  - cnt and the timer clear to 0, and the event of that cycle is discarded.
  - No snapshot is taken and load_valid stays 0.
  - port_load, router_load and low_load hold their previous values.
- **Simultaneous pg_enable and boundary:** pg_enable wins; the snapshot is suppressed.
- **Arithmetic:**
  - router_load is computed at full SUM_W width with zero-extended addends, so it cannot overflow.

## Timing
- **Reset values:** all counters 0, timer 0, port_load 0, router_load 0, load_valid 0, low_load 0.
  - low_load stays 0 until the first snapshot.
- **Epoch cadence:** the first boundary is the EPOCH_LEN-th cycle after reset deasserts.
  - load_valid is high during the following cycle, with the outputs already updated.
  - load_valid pulses every EPOCH_LEN cycles thereafter.
- **Snapshot latency:** one cycle from the boundary edge to the outputs; all outputs are registered.
- **Epoch alignment after pg_enable:** the epoch restarts, and the next boundary falls EPOCH_LEN cycles after the cycle in which pg_enable is low again.
- **Reset mid-epoch:** everything is cleared immediately, asynchronously, and the partial epoch is lost.

## Configuration
- **LOAD_EWMA_EN defined:** each port_load field is smoothed at every snapshot.
  - Update rule: port_load_i <= (port_load_i + snap_i) >> 1, computed in CNT_W+1 bits and truncated back.
  - router_load and low_load use the smoothed values.
- **LOAD_EWMA_EN undefined:** port_load_i <= snap_i, the raw saturated count.

## Test plan
All scenarios use NUM_PORTS=4, CNT_W=8, EPOCH_LEN=16, LOW_THRESH=32 unless stated otherwise.
- **Reset:** reset low mid-run, with all event inputs active -> every output is 0 immediately and stays 0 until the first boundary.
- **Single active port:** valid=4'b0001, port 0 `ACTIVE, for 16 cycles -> load_valid pulses once; port_load[0]=16, others 0; router_load=16; low_load=1.
- **Status qualification:** port 1 `INACTIVE with productive=1 and valid=0; port 2 `INACTIVE with valid=1 and productive=0; 16 cycles -> port_load[1]=16, port_load[2]=0.
- **Saturation:** CNT_W=4, EPOCH_LEN=32, all ports `ACTIVE and valid every cycle -> each port_load=15, router_load=60, no wrap.
- **pg_enable priority:** run 15 cycles with port 0 active, then pg_enable=1 on the boundary cycle -> no load_valid; outputs keep the prior snapshot; the next load_valid comes 16 cycles after pg_enable drops.
- **EWMA:** epoch 1 has port 0 active 16 cycles, epoch 2 is idle.
  - With LOAD_EWMA_EN: port_load[0]=8, then 4.
  - Without it: 16, then 0.

Source files
------------

// File: rtl/pg_load_monitor.sv
// ---------------------------------------------------------------------------
// pg_load_monitor
//
// Epoch-windowed link-utilisation monitor feeding the power-gating decision
// logic. Each port has a saturating event counter. At the end of every
// EPOCH_LEN-cycle window, a registered snapshot of the per-port loads and
// their sum is published, together with a low-load flag.
//
// Build option:
//   LOAD_EWMA_EN - when defined, each published port_load field is the
//                  running average (old + new) >> 1 rather than the raw
//                  windowed count.
//
// Ports:
//   clk                single clock, rising edge
//   reset              asynchronous active-low reset
//   pg_enable          power-gate event: clears counters and epoch timer,
//                      suppresses any snapshot in that cycle
//   valid              per-port flit present
//   productive_vector  per-port productive indication
//   port_status        per-port status, `PORT_STAT_SIZE bits per port
//   port_load          snapshot per-port load, CNT_W bits per port
//   router_load        snapshot sum of all port_load fields
//   load_valid         one-cycle pulse when a new snapshot is presented
//   low_load           router_load < LOW_THRESH (registered)
// ---------------------------------------------------------------------------
`ifndef PORT_STAT_SIZE
`define PORT_STAT_SIZE 2
`endif
`ifndef ACTIVE
`define ACTIVE 2'd1
`endif
`ifndef INACTIVE
`define INACTIVE 2'd2
`endif

module pg_load_monitor #(
  parameter int NUM_PORTS  = 4,
  parameter int CNT_W      = 8,
  parameter int EPOCH_LEN  = 256,
  parameter int LOW_THRESH = 32,
  localparam int SUM_W     = CNT_W + $clog2(NUM_PORTS)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 pg_enable,
  input  logic [NUM_PORTS-1:0]                 valid,
  input  logic [NUM_PORTS-1:0]                 productive_vector,
  input  logic [NUM_PORTS*`PORT_STAT_SIZE-1:0] port_status,
  output logic [NUM_PORTS*CNT_W-1:0]           port_load,
  output logic [SUM_W-1:0]                     router_load,
  output logic                                 load_valid,
  output logic                                 low_load
);

  localparam int TIMER_W = $clog2(EPOCH_LEN);
  localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(EPOCH_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [31:0] LOW_THRESH_U = 32'(LOW_THRESH);

  logic [CNT_W-1:0]   cntReg       [NUM_PORTS];
  logic [CNT_W-1:0]   portLoadReg  [NUM_PORTS];
  logic [CNT_W-1:0]   snap         [NUM_PORTS];
  logic [CNT_W-1:0]   portLoadNext [NUM_PORTS];
  logic [NUM_PORTS-1:0] portEvent;
  logic [TIMER_W-1:0] epochTimer;
  logic [SUM_W-1:0]   routerLoadReg;
  logic [SUM_W-1:0]   routerLoadNext;
  logic               loadValidReg;
  logic               lowLoadReg;
  logic               boundary;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [`PORT_STAT_SIZE-1:0] status;
      assign status = port_status[gi*`PORT_STAT_SIZE +: `PORT_STAT_SIZE];

      // Active ports count real flits; inactive ports count productive
      // cycles; any other status is ignored.
      assign portEvent[gi] = (valid[gi] && (status == `ACTIVE)) ||
                             (productive_vector[gi] && (status == `INACTIVE));

      // Counter value including this cycle's event, clamped at all-ones.
      assign snap[gi] = (cntReg[gi] == CNT_MAX) ? CNT_MAX
                                                : cntReg[gi] + CNT_W'(portEvent[gi]);

`ifdef LOAD_EWMA_EN
      // One extra bit keeps the carry before halving.
      logic [CNT_W:0] blendSum;
      assign blendSum = {1'b0, portLoadReg[gi]} + {1'b0, snap[gi]};
      assign portLoadNext[gi] = blendSum[CNT_W:1];
`else
      assign portLoadNext[gi] = snap[gi];
`endif

      assign port_load[gi*CNT_W +: CNT_W] = portLoadReg[gi];
    end
  endgenerate

  // Sum of the values about to be published, at full width so it cannot wrap.
  always_comb begin
    routerLoadNext = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      routerLoadNext = routerLoadNext + SUM_W'(portLoadNext[i]);
    end
  end

  assign boundary = (epochTimer == LAST_TICK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        cntReg[i]      <= '0;
        portLoadReg[i] <= '0;
      end
      epochTimer    <= '0;
      routerLoadReg <= '0;
      loadValidReg  <= 1'b0;
      lowLoadReg    <= 1'b0;
    end else begin
      loadValidReg <= 1'b0;
      if (pg_enable) begin
        // Power-gate event restarts the window and drops any snapshot.
        for (int i = 0; i < NUM_PORTS; i++) begin
          cntReg[i] <= '0;
        end
        epochTimer <= '0;
      end else if (boundary) begin
        // The boundary cycle's event goes into the snapshot only, so the
        // counters restart from zero rather than from that event.
        for (int i = 0; i < NUM_PORTS; i++) begin
          cntReg[i]      <= '0;
          portLoadReg[i] <= portLoadNext[i];
        end
        epochTimer    <= '0;
        routerLoadReg <= routerLoadNext;
        lowLoadReg    <= (32'(routerLoadNext) < LOW_THRESH_U);
        loadValidReg  <= 1'b1;
      end else begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          cntReg[i] <= snap[i];
        end
        epochTimer <= epochTimer + TIMER_W'(1);
      end
    end
  end

  assign router_load = routerLoadReg;
  assign load_valid  = loadValidReg;
  assign low_load    = lowLoadReg;

endmodule
